// File: rtl/nubus_master_ctl_if.sv
// NuBus initiator bundle: CPU request/response plus active-high bus drives.
// master: the controller side; slave: CPU and bus environment side.
interface nubus_master_ctl_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_write;
  logic        cpu_lock;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [1:0]  cpu_status;
  logic        rqst_o;
  logic [3:0]  arb_o;
  logic [3:0]  arb_i;
  logic        start_i;
  logic        start_o;
  logic [1:0]  tm_o;
  logic        tm_oe;
  logic [31:0] ad_o;
  logic        ad_oe;
  logic [31:0] ad_i;
  logic [1:0]  tm_i;
  logic        ack_i;

  modport master (
    input  cpu_valid, cpu_addr, cpu_wdata,
    input  cpu_write, cpu_lock,
    input  arb_i, start_i, ad_i, tm_i, ack_i,
    output cpu_ready, cpu_rdata, cpu_err,
    output cpu_status, rqst_o, arb_o,
    output start_o, tm_o, tm_oe, ad_o, ad_oe
  );

  modport slave (
    output cpu_valid, cpu_addr, cpu_wdata,
    output cpu_write, cpu_lock,
    output arb_i, start_i, ad_i, tm_i, ack_i,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  cpu_status, rqst_o, arb_o,
    input  start_o, tm_o, tm_oe, ad_o, ad_oe
  );
endinterface

// File: rtl/nubus_master_ctl.sv
// NuBus initiator: CPU valid/ready request -> arbitration + start/ack beat.
// Ports: mem_clk, mem_reset (sync, active-high), id (slot), bus (master).
// NUBUS_MASTER_LOCK_EN keeps bus ownership across cpu_lock transactions.
module nubus_master_ctl #(
  parameter int TIMEOUT_CLOCKS = 255,
  parameter int MAX_RETRY      = 3,
  parameter int ARB_CLOCKS     = 2
) (
  input logic                mem_clk,
  input logic                mem_reset,
  input logic [3:0]          id,
  nubus_master_ctl_if.master bus
);
`ifdef NUBUS_MASTER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int AW = $clog2(ARB_CLOCKS + 1);
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_CHECK, S_START,
    S_DATA, S_ERR, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [AW-1:0] arb_cnt_q, arb_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        busy_q, busy_d;
  logic        lock_held_q, lock_held_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:2] addr_q, addr_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  tm_q, tm_d;
  logic [31:0] wdata_q, wdata_d;
  logic        lock_q, lock_d;

  logic        enc_ok;
  logic [1:0]  enc_tm;
  logic [1:0]  enc_lo;
  logic        drive;
  logic        unused_addr;

  assign unused_addr = ^bus.cpu_addr[1:0];

  always_comb begin
    enc_ok = 1'b1;
    enc_tm = 2'b10;
    enc_lo = 2'b00;
    case (bus.cpu_write)
      4'b0001: enc_lo = 2'd0;
      4'b0010: enc_lo = 2'd1;
      4'b0100: enc_lo = 2'd2;
      4'b1000: enc_lo = 2'd3;
      4'b0011: begin
        enc_tm = 2'b11;
        enc_lo = 2'b00;
      end
      4'b1100: begin
        enc_tm = 2'b11;
        enc_lo = 2'b10;
      end
      4'b1111: begin
        enc_tm = 2'b11;
        enc_lo = 2'b11;
      end
      4'b0000: begin
        enc_tm = 2'b01;
        enc_lo = 2'b11;
      end
      default: enc_ok = 1'b0;
    endcase
  end

  // Ack wins over a simultaneous start: the tenure that ends is ours to see.
  assign busy_d = bus.ack_i ? 1'b0
                : bus.start_i ? 1'b1 : busy_q;

  always_comb begin
    state_d     = state_q;
    arb_cnt_d   = arb_cnt_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    lock_held_d = lock_held_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    tm_d        = tm_q;
    wdata_d     = wdata_q;
    lock_d      = lock_q;
    drive          = 1'b0;
    bus.cpu_ready  = 1'b0;
    bus.cpu_err    = 1'b0;
    bus.start_o    = 1'b0;
    bus.tm_o       = 2'b00;
    bus.tm_oe      = 1'b0;
    bus.ad_o       = 32'h0;
    bus.ad_oe      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Request is captured every idle clock so a dropped
        // cpu_valid cannot corrupt a transaction in flight.
        addr_d    = bus.cpu_addr[31:2];
        lo_d      = enc_lo;
        tm_d      = enc_tm;
        wdata_d   = bus.cpu_wdata;
        lock_d    = bus.cpu_lock;
        retry_d   = '0;
        arb_cnt_d = '0;
        drive = (lock_held_q | (bus.cpu_valid & enc_ok))
              & ~mem_reset;
        if (bus.cpu_valid) begin
          if (!enc_ok) begin
            status_d = 2'b01;
            state_d  = S_ERR;
          end else if (lock_held_q) begin
            if (!busy_q && !bus.start_i) state_d = S_START;
          end else begin
            // The idle clock that raises arb_o is the first settle clock.
            state_d = (ARB_CLOCKS > 1) ? S_ARB : S_CHECK;
          end
        end
      end
      S_ARB: begin
        drive     = 1'b1;
        arb_cnt_d = arb_cnt_q + AW'(1);
        if (arb_cnt_q == AW'(ARB_CLOCKS - 2)) state_d = S_CHECK;
      end
      S_CHECK: begin
        drive = 1'b1;
        if (bus.arb_i == id && !busy_q && !bus.start_i)
          state_d = S_START;
      end
      S_START: begin
        drive       = 1'b1;
        bus.start_o = 1'b1;
        bus.tm_oe   = 1'b1;
        bus.ad_oe   = 1'b1;
        bus.tm_o    = tm_q;
        bus.ad_o    = {addr_q, lo_q};
        tmo_d       = '0;
        state_d     = S_DATA;
      end
      S_DATA: begin
        drive     = 1'b1;
        bus.ad_oe = tm_q[1];
        bus.ad_o  = tm_q[1] ? wdata_q : 32'h0;
        tmo_d     = tmo_q + TW'(1);
        if (bus.ack_i) begin
          status_d = bus.tm_i;
          if (!tm_q[1]) rdata_d = bus.ad_i;
          if (bus.tm_i == 2'b11 && retry_q < RW'(MAX_RETRY)) begin
            retry_d   = retry_q + RW'(1);
            arb_cnt_d = '0;
            state_d   = (ARB_CLOCKS > 1) ? S_ARB : S_CHECK;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CLOCKS - 2)) begin
          // DONE lands exactly TIMEOUT_CLOCKS after START.
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_ERR: begin
        drive   = lock_held_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        drive         = LOCK_EN & lock_q;
        bus.cpu_ready = 1'b1;
        bus.cpu_err   = (status_q != 2'b00);
        lock_held_d   = LOCK_EN & lock_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rqst_o     = drive;
  assign bus.arb_o      = drive ? id : 4'h0;
  assign bus.cpu_status = status_q;
  assign bus.cpu_rdata  = rdata_q;

  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state_q     <= S_IDLE;
      arb_cnt_q   <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      busy_q      <= 1'b0;
      lock_held_q <= 1'b0;
      status_q    <= 2'b00;
      rdata_q     <= 32'h0;
      addr_q      <= '0;
      lo_q        <= 2'b00;
      tm_q        <= 2'b00;
      wdata_q     <= 32'h0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arb_cnt_q   <= arb_cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      busy_q      <= busy_d;
      lock_held_q <= lock_held_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      lo_q        <= lo_d;
      tm_q        <= tm_d;
      wdata_q     <= wdata_d;
      lock_q      <= lock_d;
    end
  end
endmodule

// File: tb/tb_nubus_master_ctl.sv
// Self-checking bench for nubus_master_ctl: directed plan plus random txns.
// Acts as CPU, slave and foreign masters; expectations come from a model.
module tb_nubus_master_ctl;
  localparam int TMO  = 255;
  localparam int MAXR = 3;
  localparam int ARBC = 2;
  localparam logic [3:0] MY_ID = 4'h5;
`ifdef NUBUS_MASTER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       mem_clk = 1'b0;
  logic       mem_reset;
  logic [3:0] id;
  logic       arb_ovr;
  logic       fstart;
  logic [3:0] arb_force;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         lock_held = 1'b0;

  nubus_master_ctl_if bus();

  assign bus.arb_i   = arb_ovr ? arb_force : bus.arb_o;
  assign bus.start_i = bus.start_o | fstart;

  nubus_master_ctl #(
    .TIMEOUT_CLOCKS(TMO),
    .MAX_RETRY(MAXR),
    .ARB_CLOCKS(ARBC)
  ) dut (
    .mem_clk(mem_clk),
    .mem_reset(mem_reset),
    .id(id),
    .bus(bus)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mask rules: one lane -> byte at that lane, 0011/1100 -> halves,
  // 1111 -> word write, 0000 -> word read, anything else rejected.
  function automatic void enc_model(input logic [3:0] m, output bit ok,
                                    output logic [1:0] tm,
                                    output logic [1:0] lo);
    int n;
    n  = $countones(m);
    ok = 1'b0;
    tm = 2'b00;
    lo = 2'b00;
    if (m == 4'h0) begin
      ok = 1'b1; tm = 2'b01; lo = 2'b11;
    end else if (n == 1) begin
      ok = 1'b1; tm = 2'b10;
      for (int i = 0; i < 4; i++) if (m[i]) lo = 2'(i);
    end else if (m == 4'hF) begin
      ok = 1'b1; tm = 2'b11; lo = 2'b11;
    end else if (m == 4'h3 || m == 4'hC) begin
      ok = 1'b1; tm = 2'b11; lo = m[2] ? 2'b10 : 2'b00;
    end
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_rqst"}, bus.rqst_o, 0);
    chk({tag, "_arb"}, bus.arb_o, 0);
    chk({tag, "_drv"},
        {bus.start_o, bus.tm_oe, bus.ad_oe, bus.cpu_ready, bus.cpu_err}, 0);
    chk({tag, "_stat"}, bus.cpu_status, 0);
    chk({tag, "_rd"}, bus.cpu_rdata, 0);
  endtask

  task automatic txn(input string tag, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask,
                     input bit lock, input int nretry, input logic [1:0] fin,
                     input int ack_dly, input bit noack,
                     input logic [31:0] rd, input int fs_k, input int fa_k,
                     input int arb_r);
    bit ok, wr, in_data, got;
    logic [1:0] tm, lo, exp_st;
    int k, starts, first_k, last_k, dcnt, nrsp, exp_starts, exp_first;
    enc_model(mask, ok, tm, lo);
    wr = tm[1];
    if (!ok) begin exp_st = 2'b01; exp_starts = 0; end
    else if (noack) begin exp_st = 2'b10; exp_starts = 1; end
    else if (nretry > MAXR) begin exp_st = 2'b11; exp_starts = MAXR + 1; end
    else begin exp_st = fin; exp_starts = nretry + 1; end
    exp_first = lock_held ? 1 : ARBC + 1;
    if (arb_r + 1 > exp_first) exp_first = arb_r + 1;

    @(negedge mem_clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_write = mask;
    bus.cpu_lock  = lock;
    arb_force     = ~MY_ID;
    k = 0; starts = 0; first_k = -1; last_k = -1;
    in_data = 1'b0; dcnt = 0; nrsp = 0; got = 1'b0;
    #1;
    while (!got) begin
      if (bus.cpu_ready) begin
        got = 1'b1;
        chk({tag, "_err"}, bus.cpu_err, exp_st != 2'b00);
        chk({tag, "_status"}, bus.cpu_status, exp_st);
        chk({tag, "_starts"}, starts, exp_starts);
        if (ok && !wr && exp_st == 2'b00)
          chk({tag, "_rdata"}, bus.cpu_rdata, rd);
        if (!ok)
          chk({tag, "_lat"}, k, 2);
        else if (fa_k >= 0)
          chk({tag, "_busy_hold"}, first_k > fa_k && first_k <= fa_k + 2, 1);
        else
          chk({tag, "_first_start"}, first_k, exp_first);
        if (ok && noack)
          chk({tag, "_tmo_lat"}, k - first_k, TMO);
        else if (ok)
          chk({tag, "_done_lat"}, k - last_k, 2 + ack_dly);
      end else begin
        if (ok) begin
          chk({tag, "_rqst"}, bus.rqst_o, 1);
          chk({tag, "_arbo"}, bus.arb_o, MY_ID);
        end
        if (bus.start_o) begin
          starts++;
          if (first_k < 0) first_k = k;
          last_k = k;
          chk({tag, "_ad_addr"}, bus.ad_o, {addr[31:2], lo});
          chk({tag, "_tm"}, bus.tm_o, tm);
          chk({tag, "_oe_start"}, {bus.tm_oe, bus.ad_oe}, 2'b11);
          in_data = 1'b1;
          dcnt = 0;
        end else if (in_data) begin
          chk({tag, "_oe_data"}, {bus.tm_oe, bus.ad_oe}, {1'b0, wr});
          if (wr) chk({tag, "_ad_wdata"}, bus.ad_o, wdata);
        end
      end
      bus.ack_i = 1'b0;
      bus.tm_i  = 2'($urandom);
      bus.ad_i  = $urandom;
      fstart    = (k == fs_k);
      arb_ovr   = (k < arb_r);
      if (k == fa_k) bus.ack_i = 1'b1;
      if (!got && in_data && !bus.start_o) begin
        if (!noack && dcnt == ack_dly) begin
          bus.ack_i = 1'b1;
          bus.tm_i  = (nrsp < nretry) ? 2'b11 : fin;
          bus.ad_i  = rd;
          nrsp++;
          in_data = 1'b0;
        end
        dcnt++;
      end
      if (got) bus.cpu_valid = 1'b0;
      assert (k < 2000) else begin
        n_fail++;
        $error("FAIL %s_budget: observed no cpu_ready expected one", tag);
        got = 1'b1;
        bus.cpu_valid = 1'b0;
      end
      if (!got) begin
        @(negedge mem_clk);
        k++;
      end
    end
    @(negedge mem_clk);
    bus.ack_i = 1'b0;
    fstart    = 1'b0;
    arb_ovr   = 1'b0;
    lock_held = LOCK_EN && lock;
    chk({tag, "_ready_pulse"}, bus.cpu_ready, 0);
    chk({tag, "_rqst_after"}, bus.rqst_o, lock_held);
    chk({tag, "_arb_after"}, bus.arb_o, lock_held ? MY_ID : 4'h0);
  endtask

  initial begin
    logic [3:0] legal [9];
    logic [3:0] m;
    int k;
    legal = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0, 4'h0};
    id = MY_ID;
    mem_reset = 1'b1;
    arb_ovr = 1'b0; fstart = 1'b0; arb_force = 4'h0;
    bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_write = '0; bus.cpu_lock = 1'b0;
    bus.ad_i = '0; bus.tm_i = '0; bus.ack_i = 1'b0;
    repeat (3) @(negedge mem_clk);
    chk_quiet("reset");
    mem_reset = 1'b0;

    txn("wword", 32'hF000_0000, 32'h8765_4321, 4'hF, 0, 0, 2'b00,
        1, 0, 0, -1, -1, 0);
    txn("wbyte", 32'hF000_0014, 32'h0000_00A5, 4'h4, 0, 0, 2'b00,
        0, 0, 0, -1, -1, 0);
    txn("whalf1", 32'hF000_0008, 32'hBEEF_0000, 4'hC, 0, 0, 2'b00,
        2, 0, 0, -1, -1, 0);
    txn("rword", 32'hF000_0000, 32'h0, 4'h0, 0, 0, 2'b00,
        0, 0, 32'h1234_5678, -1, -1, 0);
    txn("badmask", 32'hF000_0020, 32'h0, 4'h5, 0, 0, 2'b00,
        0, 0, 0, -1, -1, 0);
    txn("retry2", 32'hF000_0030, 32'hCAFE_F00D, 4'hF, 0, 2, 2'b00,
        1, 0, 0, -1, -1, 0);
    txn("retry4", 32'hF000_0040, 32'h0, 4'h0, 0, 4, 2'b00,
        0, 0, 32'h5555_AAAA, -1, -1, 0);
    txn("arbwait", 32'hF000_0050, 32'h1111_2222, 4'h3, 0, 0, 2'b00,
        0, 0, 0, -1, -1, 6);
    txn("busywait", 32'hF000_0060, 32'h3333_4444, 4'h1, 0, 0, 2'b00,
        0, 0, 0, 1, 6, 0);
    txn("lock1", 32'hF000_0070, 32'h0, 4'h0, 1, 0, 2'b00,
        0, 0, 32'hA5A5_5A5A, -1, -1, 0);
    txn("lock2", 32'hF000_0074, 32'h7777_8888, 4'hF, 0, 0, 2'b00,
        0, 0, 0, -1, -1, 0);
    txn("timeout", 32'hF000_0080, 32'h9999_0000, 4'hF, 0, 0, 2'b00,
        0, 1, 0, -1, -1, 0);
    // Nobody acked our tenure, so a bystander ack frees the bus.
    bus.ack_i = 1'b1;
    @(negedge mem_clk);
    bus.ack_i = 1'b0;

    @(negedge mem_clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'hF000_0090;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.cpu_write = 4'hF;
    bus.cpu_lock  = 1'b0;
    k = 0;
    while (!bus.start_o && k < 50) begin
      @(negedge mem_clk);
      k++;
    end
    chk("mrst_start_seen", bus.start_o, 1);
    @(negedge mem_clk);
    chk("mrst_data_drive", bus.ad_oe, 1);
    mem_reset = 1'b1;
    bus.cpu_valid = 1'b0;
    @(negedge mem_clk);
    chk_quiet("mrst");
    mem_reset = 1'b0;
    lock_held = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 9) m = 4'($urandom_range(0, 15));
      else m = legal[r];
      txn($sformatf("rnd%0d", i), $urandom, $urandom, m,
          1'($urandom_range(0, 1)), $urandom_range(0, 4),
          2'($urandom_range(0, 2)), $urandom_range(0, 3), 0,
          $urandom, -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
